// File: rtl/atc_pkg.sv
// Shared widths, result-type codes and forward-select encodings for the
// hazard-tag pipeline.
package atc_pkg;

  localparam int AW_DEF  = 5;
  localparam int RW_DEF  = 3;
  localparam int TW_DEF  = 2;
  localparam int NST_DEF = 3;

  typedef enum logic [RW_DEF-1:0] {
    RES_NONE = 3'd0,
    RES_ALU  = 3'd1,
    RES_DM   = 3'd2,
    RES_PC8  = 3'd3,
    RES_MD   = 3'd4
  } res_t;

  // Forward select: 0 reads the register file, s+1 bypasses from stage s.
  localparam int FWD_RF = 0;

endpackage

// File: rtl/atc_pipe_if.sv
// Issue-side and hazard-query bundle of the hazard-tag pipeline.
interface atc_pipe_if
  import atc_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int RW  = RW_DEF,
  parameter int TW  = TW_DEF,
  parameter int NST = NST_DEF,
  parameter int SW  = $clog2(NST + 1)
);

  logic [AW-1:0]     ra1i;
  logic [AW-1:0]     ra2i;
  logic [AW-1:0]     wai;
  logic [RW-1:0]     resi;
  logic [TW-1:0]     tnewi;
  logic              eclr;
  logic              flush;
  logic [AW-1:0]     rs_d;
  logic [AW-1:0]     rt_d;
  logic [TW-1:0]     tuse_rs;
  logic [TW-1:0]     tuse_rt;

  logic [NST*AW-1:0] ra1_o;
  logic [NST*AW-1:0] ra2_o;
  logic [NST*AW-1:0] wa_o;
  logic [NST*RW-1:0] res_o;
  logic [NST*TW-1:0] tnew_o;
  logic [NST-1:0]    vld_o;
  logic              stall_req;
  logic [SW-1:0]     fwd_rs;
  logic [SW-1:0]     fwd_rt;

  modport master (
    output ra1i, ra2i, wai, resi, tnewi, eclr, flush,
    output rs_d, rt_d, tuse_rs, tuse_rt,
    input  ra1_o, ra2_o, wa_o, res_o, tnew_o, vld_o,
    input  stall_req, fwd_rs, fwd_rt
  );

  modport slave (
    input  ra1i, ra2i, wai, resi, tnewi, eclr, flush,
    input  rs_d, rt_d, tuse_rs, tuse_rt,
    output ra1_o, ra2_o, wa_o, res_o, tnew_o, vld_o,
    output stall_req, fwd_rs, fwd_rt
  );

endinterface

// File: rtl/atc_stage.sv
// One back-end stage register: hazard tuple plus valid, with clear and load.
module atc_stage
  import atc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_vld,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  input  logic [AW-1:0] i_wa,
  input  logic [RW-1:0] i_res,
  input  logic [TW-1:0] i_tnew,
  output logic          o_vld,
  output logic [AW-1:0] o_ra1,
  output logic [AW-1:0] o_ra2,
  output logic [AW-1:0] o_wa,
  output logic [RW-1:0] o_res,
  output logic [TW-1:0] o_tnew
);

  logic          r_vld;
  logic [AW-1:0] r_ra1;
  logic [AW-1:0] r_ra2;
  logic [AW-1:0] r_wa;
  logic [RW-1:0] r_res;
  logic [TW-1:0] r_tnew;

  // A cleared stage is a full bubble: every field zero, not just vld.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_vld  <= 1'b0;
      r_ra1  <= '0;
      r_ra2  <= '0;
      r_wa   <= '0;
      r_res  <= '0;
      r_tnew <= '0;
    end else if (i_load) begin
      r_vld  <= i_vld;
      r_ra1  <= i_ra1;
      r_ra2  <= i_ra2;
      r_wa   <= i_wa;
      r_res  <= i_res;
      r_tnew <= i_tnew;
    end
  end

  assign o_vld  = r_vld;
  assign o_ra1  = r_ra1;
  assign o_ra2  = r_ra2;
  assign o_wa   = r_wa;
  assign o_res  = r_res;
  assign o_tnew = r_tnew;

endmodule

// File: rtl/atc_pipe.sv
// Hazard-tag pipeline: shifts instruction tuples through NST back-end stages,
// ages Tnew, and derives the D-stage stall request and forward selects.
module atc_pipe
  import atc_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int RW  = RW_DEF,
  parameter int TW  = TW_DEF,
  parameter int NST = NST_DEF,
  parameter int SW  = $clog2(NST + 1)
) (
  input  logic       clk,
  input  logic       rst,
  atc_pipe_if.slave  bus
);

  logic          w_vld_q  [NST];
  logic [AW-1:0] w_ra1_q  [NST];
  logic [AW-1:0] w_ra2_q  [NST];
  logic [AW-1:0] w_wa_q   [NST];
  logic [RW-1:0] w_res_q  [NST];
  logic [TW-1:0] w_tnew_q [NST];

  genvar gi;
  generate
    for (gi = 0; gi < NST; gi++) begin : g_st
      logic          w_clr;
      logic          w_vld_in;
      logic [AW-1:0] w_ra1_in;
      logic [AW-1:0] w_ra2_in;
      logic [AW-1:0] w_wa_in;
      logic [RW-1:0] w_res_in;
      logic [TW-1:0] w_tnew_in;

      if (gi == 0) begin : g_head
        assign w_clr     = bus.flush | bus.eclr;
        assign w_vld_in  = 1'b1;
        assign w_ra1_in  = bus.ra1i;
        assign w_ra2_in  = bus.ra2i;
        assign w_wa_in   = bus.wai;
        assign w_res_in  = bus.resi;
        assign w_tnew_in = bus.tnewi;
      end else begin : g_tail
        // Later stages never hold; only flush clears them.
        assign w_clr     = bus.flush;
        assign w_vld_in  = w_vld_q[gi-1];
        assign w_ra1_in  = w_ra1_q[gi-1];
        assign w_ra2_in  = w_ra2_q[gi-1];
        assign w_wa_in   = w_wa_q[gi-1];
        assign w_res_in  = w_res_q[gi-1];
        assign w_tnew_in = (w_tnew_q[gi-1] == '0) ? '0 : w_tnew_q[gi-1] - TW'(1);
      end

      atc_stage #(
        .AW (AW),
        .RW (RW),
        .TW (TW)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_load (1'b1),
        .i_vld  (w_vld_in),
        .i_ra1  (w_ra1_in),
        .i_ra2  (w_ra2_in),
        .i_wa   (w_wa_in),
        .i_res  (w_res_in),
        .i_tnew (w_tnew_in),
        .o_vld  (w_vld_q[gi]),
        .o_ra1  (w_ra1_q[gi]),
        .o_ra2  (w_ra2_q[gi]),
        .o_wa   (w_wa_q[gi]),
        .o_res  (w_res_q[gi]),
        .o_tnew (w_tnew_q[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.ra1_o  = '0;
    bus.ra2_o  = '0;
    bus.wa_o   = '0;
    bus.res_o  = '0;
    bus.tnew_o = '0;
    bus.vld_o  = '0;
    for (int s = 0; s < NST; s++) begin
      bus.ra1_o[s*AW +: AW]  = w_ra1_q[s];
      bus.ra2_o[s*AW +: AW]  = w_ra2_q[s];
      bus.wa_o[s*AW +: AW]   = w_wa_q[s];
      bus.res_o[s*RW +: RW]  = w_res_q[s];
      bus.tnew_o[s*TW +: TW] = w_tnew_q[s];
      bus.vld_o[s]           = w_vld_q[s];
    end
  end

  logic          w_prod_rs [NST];
  logic          w_prod_rt [NST];
  logic          w_stall_rs;
  logic          w_stall_rt;
  logic [SW-1:0] w_fwd_rs;
  logic [SW-1:0] w_fwd_rt;

  // Register 0 is excluded by requiring a non-zero destination.
  always_comb begin
    for (int s = 0; s < NST; s++) begin
      w_prod_rs[s] = w_vld_q[s] && (w_wa_q[s] != '0) && (w_wa_q[s] == bus.rs_d);
      w_prod_rt[s] = w_vld_q[s] && (w_wa_q[s] != '0) && (w_wa_q[s] == bus.rt_d);
    end
  end

  // Scan oldest to youngest so the youngest producer's choice lands last.
  always_comb begin
    w_stall_rs = 1'b0;
    w_stall_rt = 1'b0;
    w_fwd_rs   = SW'(FWD_RF);
    w_fwd_rt   = SW'(FWD_RF);
    for (int s = NST - 1; s >= 0; s--) begin
      if (w_prod_rs[s]) begin
        if (w_tnew_q[s] > bus.tuse_rs) w_stall_rs = 1'b1;
        w_fwd_rs = (w_tnew_q[s] == '0) ? SW'(s + 1) : SW'(FWD_RF);
      end
      if (w_prod_rt[s]) begin
        if (w_tnew_q[s] > bus.tuse_rt) w_stall_rt = 1'b1;
        w_fwd_rt = (w_tnew_q[s] == '0) ? SW'(s + 1) : SW'(FWD_RF);
      end
    end
  end

  assign bus.stall_req = w_stall_rs | w_stall_rt;
  assign bus.fwd_rs    = w_fwd_rs;
  assign bus.fwd_rt    = w_fwd_rt;

endmodule

// File: tb/tb_atc_pipe.sv
// Self-checking bench for atc_pipe: directed scenarios plus randomized traffic
// checked against an issue-history model.
module tb_atc_pipe;
  import atc_pkg::*;

  localparam int AW  = 5;
  localparam int RW  = 3;
  localparam int TW  = 2;
  localparam int NST = 3;
  localparam int SW  = $clog2(NST + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  atc_pipe_if #(.AW(AW), .RW(RW), .TW(TW), .NST(NST), .SW(SW)) bus ();

  atc_pipe #(.AW(AW), .RW(RW), .TW(TW), .NST(NST), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa;
    logic [RW-1:0] res;
    logic [TW-1:0] tn;
  } ent_t;

  // hist[k] is the instruction issued k edges ago (zero if bubble/flushed).
  ent_t hist [NST];

  task automatic model_edge();
    if (rst || bus.flush) begin
      for (int k = 0; k < NST; k++) hist[k] = '0;
    end else begin
      for (int k = NST - 1; k >= 1; k--) hist[k] = hist[k-1];
      if (bus.eclr) hist[0] = '0;
      else hist[0] = '{v: 1'b1, ra1: bus.ra1i, ra2: bus.ra2i, wa: bus.wai,
                       res: bus.resi, tn: bus.tnewi};
    end
  endtask

  // Tnew after k stages of ageing is the issued value minus k, floored at 0.
  function automatic logic [TW-1:0] age_tnew(int k);
    int t;
    t = int'(hist[k].tn) - k;
    if (t < 0) t = 0;
    return TW'(t);
  endfunction

  function automatic logic exp_stall();
    logic st;
    st = 1'b0;
    for (int k = 0; k < NST; k++) begin
      if (hist[k].v && hist[k].wa != 0) begin
        if (hist[k].wa == bus.rs_d && age_tnew(k) > bus.tuse_rs) st = 1'b1;
        if (hist[k].wa == bus.rt_d && age_tnew(k) > bus.tuse_rt) st = 1'b1;
      end
    end
    return st;
  endfunction

  function automatic logic [SW-1:0] exp_fwd(logic [AW-1:0] r);
    for (int k = 0; k < NST; k++) begin
      if (hist[k].v && hist[k].wa != 0 && hist[k].wa == r)
        return (age_tnew(k) == 0) ? SW'(k + 1) : SW'(0);
    end
    return SW'(0);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] wa, input logic [TW-1:0] tn);
    bus.eclr  = 1'b0;
    bus.flush = 1'b0;
    bus.ra1i  = AW'(wa + 1);
    bus.ra2i  = AW'(wa + 2);
    bus.wai   = wa;
    bus.resi  = RES_ALU;
    bus.tnewi = tn;
    tick();
  endtask

  task automatic bubble();
    bus.eclr  = 1'b1;
    bus.flush = 1'b0;
    tick();
  endtask

  task automatic do_flush();
    bus.eclr  = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    issue(5'd8, 2'd2);
    checks++;
    if (bus.vld_o !== 3'b001) begin
      errors++; $display("FAIL reset_preload vld_o got %b exp %b", bus.vld_o, 3'b001);
    end
    rst = 1'b1;
    bus.rs_d = 5'd8; bus.rt_d = 5'd8;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.vld_o !== '0 || bus.wa_o !== '0 || bus.ra1_o !== '0 || bus.ra2_o !== '0 ||
        bus.res_o !== '0 || bus.tnew_o !== '0) begin
      errors++;
      $display("FAIL reset_state vld %b wa %h ra1 %h ra2 %h res %h tnew %h exp all 0",
               bus.vld_o, bus.wa_o, bus.ra1_o, bus.ra2_o, bus.res_o, bus.tnew_o);
    end
    checks++;
    if (bus.stall_req !== 1'b0 || bus.fwd_rs !== '0 || bus.fwd_rt !== '0) begin
      errors++;
      $display("FAIL reset_hazard stall %b fwd_rs %0d fwd_rt %0d exp 0 0 0",
               bus.stall_req, bus.fwd_rs, bus.fwd_rt);
    end
    $display("test_reset done");
  endtask

  task automatic test_aging();
    logic [1:0] exp_st [3];
    exp_st = '{1'b1, 1'b1, 1'b0};
    bus.rs_d = 5'd8; bus.tuse_rs = 2'd0; bus.rt_d = 5'd0; bus.tuse_rt = 2'd0;
    issue(5'd8, 2'd2);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.tnew_o[c*TW +: TW] !== TW'(2 - c) || bus.vld_o !== 3'(1 << c)) begin
        errors++;
        $display("FAIL aging_tnew cyc %0d tnew %0d vld %b exp %0d %b",
                 c, bus.tnew_o[c*TW +: TW], bus.vld_o, 2 - c, 3'(1 << c));
      end
      checks++;
      if (bus.stall_req !== exp_st[c][0]) begin
        errors++;
        $display("FAIL aging_stall cyc %0d got %b exp %b", c, bus.stall_req, exp_st[c][0]);
      end
      if (c < 2) bubble();
    end
    checks++;
    if (bus.fwd_rs !== 2'd3 || bus.wa_o[14:10] !== 5'd8) begin
      errors++;
      $display("FAIL aging_fwd fwd_rs %0d wa2 %0d exp 3 8", bus.fwd_rs, bus.wa_o[14:10]);
    end
    $display("test_aging done");
  endtask

  task automatic test_load_use();
    do_flush();
    bus.rs_d = 5'd0; bus.rt_d = 5'd5; bus.tuse_rt = 2'd1; bus.tuse_rs = 2'd0;
    issue(5'd5, 2'd2);
    checks++;
    if (bus.stall_req !== 1'b1) begin
      errors++; $display("FAIL load_use_stall got %b exp 1", bus.stall_req);
    end
    bubble();
    checks++;
    if (bus.vld_o[0] !== 1'b0 || bus.tnew_o[3:2] !== 2'd1 || bus.stall_req !== 1'b0 ||
        bus.fwd_rt !== 2'd0) begin
      errors++;
      $display("FAIL load_use_release vld0 %b tnew1 %0d stall %b fwd_rt %0d exp 0 1 0 0",
               bus.vld_o[0], bus.tnew_o[3:2], bus.stall_req, bus.fwd_rt);
    end
    $display("test_load_use done");
  endtask

  task automatic test_youngest();
    do_flush();
    bus.rs_d = 5'd4; bus.tuse_rs = 2'd0; bus.rt_d = 5'd0;
    issue(5'd4, 2'd1);
    issue(5'd4, 2'd0);
    checks++;
    if (bus.fwd_rs !== 2'd1 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL youngest_ready fwd_rs %0d stall %b exp 1 0", bus.fwd_rs, bus.stall_req);
    end
    do_flush();
    issue(5'd4, 2'd1);
    issue(5'd4, 2'd1);
    checks++;
    if (bus.fwd_rs !== 2'd0 || bus.stall_req !== 1'b1) begin
      errors++;
      $display("FAIL youngest_notready fwd_rs %0d stall %b exp 0 1", bus.fwd_rs, bus.stall_req);
    end
    $display("test_youngest done");
  endtask

  task automatic test_zero();
    do_flush();
    bus.rs_d = 5'd0; bus.rt_d = 5'd0; bus.tuse_rs = 2'd0; bus.tuse_rt = 2'd0;
    issue(5'd0, 2'd3);
    issue(5'd0, 2'd3);
    issue(5'd0, 2'd0);
    checks++;
    if (bus.vld_o !== 3'b111 || bus.stall_req !== 1'b0 || bus.fwd_rs !== '0 ||
        bus.fwd_rt !== '0) begin
      errors++;
      $display("FAIL zero_reg vld %b stall %b fwd_rs %0d fwd_rt %0d exp 111 0 0 0",
               bus.vld_o, bus.stall_req, bus.fwd_rs, bus.fwd_rt);
    end
    $display("test_zero done");
  endtask

  task automatic test_flush_eclr();
    issue(5'd1, 2'd3);
    issue(5'd2, 2'd3);
    issue(5'd3, 2'd3);
    bus.eclr = 1'b1; bus.flush = 1'b1;
    tick();
    checks++;
    if (bus.vld_o !== '0 || bus.wa_o !== '0 || bus.tnew_o !== '0 || bus.ra1_o !== '0) begin
      errors++;
      $display("FAIL flush_eclr vld %b wa %h tnew %h ra1 %h exp all 0",
               bus.vld_o, bus.wa_o, bus.tnew_o, bus.ra1_o);
    end
    issue(5'd9, 2'd2);
    checks++;
    if (bus.vld_o !== 3'b001 || bus.wa_o !== 15'd9 || bus.tnew_o !== 6'd2) begin
      errors++;
      $display("FAIL flush_refill vld %b wa %h tnew %h exp 001 0009 02",
               bus.vld_o, bus.wa_o, bus.tnew_o);
    end
    $display("test_flush_eclr done");
  endtask

  task automatic test_random();
    logic [NST*AW-1:0] e_ra1, e_ra2, e_wa;
    logic [NST*RW-1:0] e_res;
    logic [NST*TW-1:0] e_tn;
    logic [NST-1:0]    e_vld;
    for (int n = 0; n < 200; n++) begin
      bus.rs_d    = AW'($urandom_range(0, 6));
      bus.rt_d    = AW'($urandom_range(0, 6));
      bus.tuse_rs = TW'($urandom);
      bus.tuse_rt = TW'($urandom);
      #1;
      for (int k = 0; k < NST; k++) begin
        e_ra1[k*AW +: AW] = hist[k].ra1;
        e_ra2[k*AW +: AW] = hist[k].ra2;
        e_wa[k*AW +: AW]  = hist[k].wa;
        e_res[k*RW +: RW] = hist[k].res;
        e_tn[k*TW +: TW]  = age_tnew(k);
        e_vld[k]          = hist[k].v;
      end
      checks++;
      if (bus.vld_o !== e_vld || bus.wa_o !== e_wa || bus.ra1_o !== e_ra1 ||
          bus.ra2_o !== e_ra2 || bus.res_o !== e_res || bus.tnew_o !== e_tn) begin
        errors++;
        $display("FAIL rand_regs n %0d vld %b/%b wa %h/%h ra1 %h/%h ra2 %h/%h res %h/%h tnew %h/%h",
                 n, bus.vld_o, e_vld, bus.wa_o, e_wa, bus.ra1_o, e_ra1, bus.ra2_o, e_ra2,
                 bus.res_o, e_res, bus.tnew_o, e_tn);
      end
      checks++;
      if (bus.stall_req !== exp_stall() || bus.fwd_rs !== exp_fwd(bus.rs_d) ||
          bus.fwd_rt !== exp_fwd(bus.rt_d)) begin
        errors++;
        $display("FAIL rand_hazard n %0d stall %b/%b fwd_rs %0d/%0d fwd_rt %0d/%0d",
                 n, bus.stall_req, exp_stall(), bus.fwd_rs, exp_fwd(bus.rs_d),
                 bus.fwd_rt, exp_fwd(bus.rt_d));
      end
      $display("txn %0d rs %0d rt %0d stall %b fwd_rs %0d fwd_rt %0d vld %b",
               n, bus.rs_d, bus.rt_d, bus.stall_req, bus.fwd_rs, bus.fwd_rt, bus.vld_o);
      rst       = ($urandom_range(0, 49) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.eclr  = ($urandom_range(0, 3) == 0);
      bus.ra1i  = AW'($urandom);
      bus.ra2i  = AW'($urandom);
      bus.wai   = AW'($urandom_range(0, 6));
      bus.resi  = RW'($urandom_range(0, 4));
      bus.tnewi = TW'($urandom);
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NST; k++) hist[k] = '0;
    bus.ra1i = '0; bus.ra2i = '0; bus.wai = '0; bus.resi = '0; bus.tnewi = '0;
    bus.eclr = 1'b0; bus.flush = 1'b0;
    bus.rs_d = '0; bus.rt_d = '0; bus.tuse_rs = '0; bus.tuse_rt = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_aging();
    test_load_use();
    test_youngest();
    test_zero();
    test_flush_eclr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
